// File: rtl/seq_detector_param.sv
// Serial pattern detector over a PAT_LEN-bit sliding window.
// Bits advance only on en. A match produces a registered one-cycle pulse
// and bumps a saturating match counter. OVERLAP chooses whether the
// completing bit may also start the next occurrence.
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b0110,
    parameter int                 OVERLAP = 0,
    parameter int                 CNT_W   = 8,
    localparam int                FILL_W  = $clog2(PAT_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              data_in,
    input  logic              clear_count,
    output logic              detected,
    output logic [CNT_W-1:0]  match_count,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] history_q, history_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               detected_q, detected_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;

    logic [PAT_LEN-1:0] hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               match;

    // Next-state: shift window, track fill, detect and count matches.
    always_comb begin
        hist_shift    = {history_q[PAT_LEN-2:0], data_in};
        fill_inc      = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
        match         = en && (fill_inc == FILL_MAX) && (hist_shift == PATTERN);

        history_d     = history_q;
        fill_d        = fill_q;
        detected_d    = match;
        match_count_d = match_count_q;

        if (en) begin
            history_d = hist_shift;
            // Non-overlapping mode forgets the window so the completing bit
            // cannot contribute to the next occurrence.
            fill_d    = (match && (OVERLAP == 0)) ? '0 : fill_inc;
        end

        if (clear_count) begin
            match_count_d = match ? CNT_W'(1) : '0;
        end else if (match && (match_count_q != CNT_MAX)) begin
            match_count_d = match_count_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            history_q     <= '0;
            fill_q        <= '0;
            detected_q    <= 1'b0;
            match_count_q <= '0;
        end else begin
            history_q     <= history_d;
            fill_q        <= fill_d;
            detected_q    <= detected_d;
            match_count_q <= match_count_d;
        end
    end

    assign detected    = detected_q;
    assign match_count = match_count_q;
    assign fill        = fill_q;

endmodule
